// File: rtl/ins_mem_sync.sv
// Loadable instruction memory with a one-cycle registered read, fetch stall/flush and fault reporting.
// Optional word parity is compiled in when INS_MEM_PARITY_EN is defined.
module ins_mem_sync #(
    parameter int DATA_LEN    = 32,
    parameter int ADDRESS_LEN = 32,
    parameter int DEPTH       = 64,
    parameter int CNT_LEN     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fetch_req,
    input  logic [ADDRESS_LEN-1:0] address,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   load_en,
    input  logic [ADDRESS_LEN-1:0] load_addr,
    input  logic [DATA_LEN-1:0]    load_data,
    input  logic                   load_par_inv,
    output logic                   ins_valid,
    output logic [DATA_LEN-1:0]    ins_out,
    output logic [ADDRESS_LEN-1:0] ins_addr,
    output logic                   ins_fault,
    output logic                   ins_parity_err,
    output logic                   load_err,
    output logic [CNT_LEN-1:0]     fetch_count
);

    localparam int IDX_W  = ADDRESS_LEN - 2;
    localparam int MEM_AW = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);

    logic [DATA_LEN-1:0] mem_q [DEPTH];

    logic [IDX_W-1:0]  fetch_idx, load_idx;
    logic [MEM_AW-1:0] fetch_word, load_word;
    logic              fetch_ok, load_ok, load_we, load_hit, accept;
    logic [DATA_LEN-1:0] rd_word;
    logic              par_bad;

    logic                   ins_valid_d, ins_valid_q;
    logic [DATA_LEN-1:0]    ins_out_d, ins_out_q;
    logic [ADDRESS_LEN-1:0] ins_addr_d, ins_addr_q;
    logic                   ins_fault_d, ins_fault_q;
    logic                   ins_parity_err_d, ins_parity_err_q;
    logic                   load_err_d, load_err_q;
    logic [CNT_LEN-1:0]     fetch_count_d, fetch_count_q;

    // The full index is range-checked so out-of-range upper bits fault instead of aliasing.
    assign fetch_idx  = address[ADDRESS_LEN-1:2];
    assign load_idx   = load_addr[ADDRESS_LEN-1:2];
    assign fetch_word = fetch_idx[MEM_AW-1:0];
    assign load_word  = load_idx[MEM_AW-1:0];
    assign fetch_ok   = (address[1:0] == 2'b00) && (fetch_idx < DEPTH_IDX);
    assign load_ok    = (load_addr[1:0] == 2'b00) && (load_idx < DEPTH_IDX);
    assign load_we    = load_en && load_ok && !rst;
    assign load_hit   = load_we && (load_idx == fetch_idx);
    assign accept     = fetch_req && !stall && !flush;
    assign rd_word    = load_hit ? load_data : mem_q[fetch_word];

`ifdef INS_MEM_PARITY_EN
    logic par_q [DEPTH];
    logic load_par, rd_par;

    assign load_par = (^load_data) ^ load_par_inv;
    assign rd_par   = load_hit ? load_par : par_q[fetch_word];
    assign par_bad  = (^rd_word) != rd_par;

    always_ff @(posedge clk) begin
        if (load_we) par_q[load_word] <= load_par;
    end
`else
    logic unused_par_inv;
    assign unused_par_inv = load_par_inv;
    assign par_bad        = 1'b0;
`endif

    // NOTE: storage arrays have no reset; contents must survive rst, and this keeps them mappable to RAM.
    always_ff @(posedge clk) begin
        if (load_we) mem_q[load_word] <= load_data;
    end

    always_comb begin
        ins_valid_d      = ins_valid_q;
        ins_out_d        = ins_out_q;
        ins_addr_d       = ins_addr_q;
        ins_fault_d      = ins_fault_q;
        ins_parity_err_d = ins_parity_err_q;
        fetch_count_d    = fetch_count_q;
        load_err_d       = load_en && !load_ok;

        if (flush) begin
            ins_valid_d      = 1'b0;
            ins_fault_d      = 1'b0;
            ins_parity_err_d = 1'b0;
        end else if (stall) begin
            ins_valid_d = ins_valid_q;
        end else if (accept) begin
            ins_valid_d      = 1'b1;
            ins_addr_d       = address;
            ins_fault_d      = !fetch_ok;
            ins_parity_err_d = fetch_ok && par_bad;
            ins_out_d        = (fetch_ok && !par_bad) ? rd_word : '0;
            if (fetch_count_q != '1) fetch_count_d = fetch_count_q + CNT_LEN'(1);
        end else begin
            ins_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ins_valid_q      <= 1'b0;
            ins_out_q        <= '0;
            ins_addr_q       <= '0;
            ins_fault_q      <= 1'b0;
            ins_parity_err_q <= 1'b0;
            load_err_q       <= 1'b0;
            fetch_count_q    <= '0;
        end else begin
            ins_valid_q      <= ins_valid_d;
            ins_out_q        <= ins_out_d;
            ins_addr_q       <= ins_addr_d;
            ins_fault_q      <= ins_fault_d;
            ins_parity_err_q <= ins_parity_err_d;
            load_err_q       <= load_err_d;
            fetch_count_q    <= fetch_count_d;
        end
    end

    assign ins_valid      = ins_valid_q;
    assign ins_out        = ins_out_q;
    assign ins_addr       = ins_addr_q;
    assign ins_fault      = ins_fault_q;
    assign ins_parity_err = ins_parity_err_q;
    assign load_err       = load_err_q;
    assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_ins_mem_sync.sv
// Directed bench for ins_mem_sync with DEPTH=12 (non power of two) and a 4-bit saturating fetch counter.
module tb_ins_mem_sync;

    localparam int DL = 32;
    localparam int AL = 32;
    localparam int DEPTH = 12;
    localparam int CL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_req, stall, flush, load_en, load_par_inv;
    logic [AL-1:0] address, load_addr;
    logic [DL-1:0] load_data;
    logic          ins_valid, ins_fault, ins_parity_err, load_err;
    logic [DL-1:0] ins_out;
    logic [AL-1:0] ins_addr;
    logic [CL-1:0] fetch_count;

    int n_vec = 0;
    int n_bad = 0;
    int exp_cnt = 0;

    ins_mem_sync #(.DATA_LEN(DL), .ADDRESS_LEN(AL), .DEPTH(DEPTH), .CNT_LEN(CL)) dut (
        .clk(clk), .rst(rst), .fetch_req(fetch_req), .address(address), .stall(stall),
        .flush(flush), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .load_par_inv(load_par_inv), .ins_valid(ins_valid), .ins_out(ins_out),
        .ins_addr(ins_addr), .ins_fault(ins_fault), .ins_parity_err(ins_parity_err),
        .load_err(load_err), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [AL-1:0] a);
        fetch_req = 1'b1;
        address   = a;
        tick();
        if (exp_cnt < 15) exp_cnt++;
    endtask

    task automatic expect_fetch(input string tag, input logic v, input logic [DL-1:0] d,
                                input logic [AL-1:0] a, input logic f);
        check({tag, ".valid"}, 64'(ins_valid), 64'(v));
        check({tag, ".out"}, 64'(ins_out), 64'(d));
        check({tag, ".addr"}, 64'(ins_addr), 64'(a));
        check({tag, ".fault"}, 64'(ins_fault), 64'(f));
        check({tag, ".count"}, 64'(fetch_count), 64'(exp_cnt));
    endtask

    initial begin
        rst = 1'b1; fetch_req = 1'b0; stall = 1'b0; flush = 1'b0;
        load_en = 1'b0; load_par_inv = 1'b0; address = '0; load_addr = '0; load_data = '0;
        tick();
        expect_fetch("reset", 1'b0, 32'h0, 32'h0, 1'b0);
        check("reset.perr", 64'(ins_parity_err), 64'd0);
        check("reset.lerr", 64'(load_err), 64'd0);

        rst = 1'b0;
        load_en = 1'b1; load_addr = 32'd0; load_data = 32'hE3A00014; tick();
        load_addr = 32'd4; load_data = 32'hE3A01A01; tick();
        load_en = 1'b0;

        fetch(32'd0); expect_fetch("f0", 1'b1, 32'hE3A00014, 32'd0, 1'b0);
        fetch(32'd4); expect_fetch("f4", 1'b1, 32'hE3A01A01, 32'd4, 1'b0);
        fetch_req = 1'b0; tick();
        expect_fetch("idle", 1'b0, 32'hE3A01A01, 32'd4, 1'b0);

        fetch(32'd2);  expect_fetch("misalign", 1'b1, 32'h0, 32'd2, 1'b1);
        fetch(32'd48); expect_fetch("idx_depth", 1'b1, 32'h0, 32'd48, 1'b1);

        fetch_req = 1'b0; load_en = 1'b1; load_addr = 32'd44; load_data = 32'hA5A50044; tick();
        check("load44.lerr", 64'(load_err), 64'd0);
        load_en = 1'b0;
        fetch(32'd44); expect_fetch("idx_last", 1'b1, 32'hA5A50044, 32'd44, 1'b0);
        fetch(32'h8000_0000); expect_fetch("alias", 1'b1, 32'h0, 32'h8000_0000, 1'b1);

        fetch_req = 1'b0; load_en = 1'b1; load_addr = 32'd48; load_data = 32'hDEADBEEF; tick();
        check("badload.pulse", 64'(load_err), 64'd1);
        load_en = 1'b0; tick();
        check("badload.clear", 64'(load_err), 64'd0);
        load_en = 1'b1; load_addr = 32'h8000_0000; tick();
        check("aliasload.pulse", 64'(load_err), 64'd1);
        load_en = 1'b0; tick();
        check("aliasload.clear", 64'(load_err), 64'd0);
        fetch(32'd0); expect_fetch("mem_intact", 1'b1, 32'hE3A00014, 32'd0, 1'b0);

        stall = 1'b1; address = 32'd8;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_fetch("stall", 1'b1, 32'hE3A00014, 32'd0, 1'b0);
        end
        flush = 1'b1; tick();
        check("stall_flush.valid", 64'(ins_valid), 64'd0);
        check("stall_flush.count", 64'(fetch_count), 64'(exp_cnt));
        stall = 1'b0; flush = 1'b0;

        fetch(32'd2); expect_fetch("fault_pre", 1'b1, 32'h0, 32'd2, 1'b1);
        flush = 1'b1; tick();
        check("flush.valid", 64'(ins_valid), 64'd0);
        check("flush.fault", 64'(ins_fault), 64'd0);
        check("flush.count", 64'(fetch_count), 64'(exp_cnt));
        flush = 1'b0;

        load_en = 1'b1; load_addr = 32'd20; load_data = 32'h12345678;
        fetch(32'd20); expect_fetch("wr_first", 1'b1, 32'h12345678, 32'd20, 1'b0);
        load_en = 1'b0;
        fetch(32'd20); expect_fetch("wr_kept", 1'b1, 32'h12345678, 32'd20, 1'b0);

        fetch_req = 1'b0; load_en = 1'b1; load_addr = 32'd8; load_data = 32'h0000_0007;
        load_par_inv = 1'b1; tick();
        load_en = 1'b0; load_par_inv = 1'b0;
        fetch(32'd8);
`ifdef INS_MEM_PARITY_EN
        expect_fetch("par_bad", 1'b1, 32'h0, 32'd8, 1'b0);
        check("par_bad.perr", 64'(ins_parity_err), 64'd1);
`else
        expect_fetch("par_bad", 1'b1, 32'h0000_0007, 32'd8, 1'b0);
        check("par_bad.perr", 64'(ins_parity_err), 64'd0);
`endif
        fetch(32'd0); expect_fetch("par_clear", 1'b1, 32'hE3A00014, 32'd0, 1'b0);
        check("par_clear.perr", 64'(ins_parity_err), 64'd0);

        for (int i = 0; i < 8; i++) begin
            fetch(32'd4);
            check("saturate.count", 64'(fetch_count), 64'(exp_cnt));
        end
        check("saturate.final", 64'(fetch_count), 64'd15);

        rst = 1'b1; load_en = 1'b1; load_addr = 32'd0; load_data = 32'hFFFFFFFF; fetch_req = 1'b1;
        tick();
        exp_cnt = 0;
        expect_fetch("midreset", 1'b0, 32'h0, 32'h0, 1'b0);
        check("midreset.perr", 64'(ins_parity_err), 64'd0);
        check("midreset.lerr", 64'(load_err), 64'd0);
        rst = 1'b0; load_en = 1'b0;
        fetch(32'd0); expect_fetch("post_reset", 1'b1, 32'hE3A00014, 32'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
